// File: rtl/servo_pkg.sv
// Shared constants and helpers for the servo position scheduler and PWM side.
// Widths, board-clock tick period and the rate-limited step toward a target.
package servo_pkg;

  localparam int POS_W          = 8;
  localparam int RATE_W         = 4;
  localparam int RST_POS_DEF    = 128;
  localparam int STEP_DIV_12MHZ = 240000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_t;

  // One rate-limited step, done in POS_W+1 bits so the clamp sees past 0/255.
  function automatic logic [POS_W-1:0] step_toward(
    input logic [POS_W-1:0]  cur,
    input logic [POS_W-1:0]  tgt,
    input logic [RATE_W-1:0] rate
  );
    logic [POS_W:0] w_up;
    logic [POS_W:0] w_dn_lim;
    logic [POS_W-1:0] w_res;
    w_up     = {1'b0, cur} + (POS_W+1)'(rate);
    w_dn_lim = {1'b0, tgt} + (POS_W+1)'(rate);
    if (cur < tgt) begin
      w_res = (w_up > {1'b0, tgt}) ? tgt : w_up[POS_W-1:0];
    end else if (cur > tgt) begin
      w_res = (w_dn_lim > {1'b0, cur}) ? tgt : (cur - POS_W'(rate));
    end else begin
      w_res = cur;
    end
    return w_res;
  endfunction

endpackage

// File: rtl/servo_tick_div.sv
// Free-running modulo-DIV counter; o_tick is a registered one-cycle pulse
// issued once per DIV clocks.
module servo_tick_div
  import servo_pkg::*;
#(
  parameter int DIV = STEP_DIV_12MHZ
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;
  logic             w_wrap;

  assign w_wrap = (r_cnt == CNT_W'(DIV - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_wrap;
      r_cnt  <= w_wrap ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/servo_ramp_ctrl.sv
// Rate-limited position scheduler: once per ramp tick every channel's current
// position steps toward its target, one channel per clock, round-robin.
//   state   | meaning
//   ST_IDLE | waiting for tick; writes accepted
//   ST_SCAN | stepping channel r_idx; writes stalled
module servo_ramp_ctrl
  import servo_pkg::*;
#(
  parameter  int NCH      = 4,
  parameter  int STEP_DIV = STEP_DIV_12MHZ,
  parameter  int RST_POS  = RST_POS_DEF,
  localparam int CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_wr_valid,
  output logic                   o_wr_ready,
  input  logic [CH_W-1:0]        i_wr_ch,
  input  logic [POS_W-1:0]       i_wr_pos,
  input  logic [RATE_W-1:0]      i_wr_rate,
  output logic [NCH*POS_W-1:0]   o_pos_out,
  output logic [NCH-1:0]         o_busy,
  output logic                   o_tick
);

  logic [POS_W-1:0]  r_cur  [NCH];
  logic [POS_W-1:0]  r_tgt  [NCH];
  logic [RATE_W-1:0] r_rate [NCH];
  scan_state_t       r_state;
  logic [CH_W-1:0]   r_idx;
  logic              r_wr_ready;
  logic [NCH-1:0]    r_busy;

  logic              w_tick;
  logic              w_wr_acc;
  logic              w_ch_ok;
  logic [POS_W-1:0]  w_step;

  servo_tick_div #(
    .DIV (STEP_DIV)
  ) u_tick_div (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_tick (w_tick)
  );

  assign w_wr_acc = i_wr_valid & r_wr_ready;
  // Out-of-range channel indices are accepted but dropped.
  assign w_ch_ok  = ({1'b0, i_wr_ch} < (CH_W+1)'(NCH));
  assign w_step   = step_toward(r_cur[r_idx], r_tgt[r_idx], r_rate[r_idx]);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_wr_ready <= 1'b1;
      for (int k = 0; k < NCH; k++) begin
        r_cur[k]  <= POS_W'(RST_POS);
        r_tgt[k]  <= POS_W'(RST_POS);
        r_rate[k] <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_tick) begin
            r_state    <= ST_SCAN;
            r_idx      <= '0;
            r_wr_ready <= 1'b0;
          end
        end
        ST_SCAN: begin
          r_cur[r_idx] <= w_step;
          if (r_idx == CH_W'(NCH - 1)) begin
            r_state    <= ST_IDLE;
            r_wr_ready <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_wr_ready <= 1'b1;
        end
      endcase
      // Writes only land in IDLE, so they never collide with a scan update.
      if (w_wr_acc && w_ch_ok) begin
        r_tgt[i_wr_ch]  <= i_wr_pos;
        r_rate[i_wr_ch] <= i_wr_rate;
        if (i_wr_rate == '0) begin
          r_cur[i_wr_ch] <= i_wr_pos;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        r_busy[k] <= (r_cur[k] != r_tgt[k]);
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    assign o_pos_out[g*POS_W +: POS_W] = r_cur[g];
  end

  assign o_busy     = r_busy;
  assign o_wr_ready = r_wr_ready;
  assign o_tick     = w_tick;

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Scoreboard bench for servo_ramp_ctrl: a per-cycle reference model pushes the
// expected outputs, a negedge monitor pops and compares them.
module tb_servo_ramp_ctrl;

  localparam int NCH = 4;
  localparam int SD  = 16;
  localparam int RP  = 128;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic [1:0]  wr_ch = '0;
  logic [7:0]  wr_pos = '0;
  logic [3:0]  wr_rate = '0;
  logic        wr_ready;
  logic [31:0] pos_out;
  logic [3:0]  busy;
  logic        tick;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  servo_ramp_ctrl #(
    .NCH      (NCH),
    .STEP_DIV (SD),
    .RST_POS  (RP)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_wr_valid (wr_valid),
    .o_wr_ready (wr_ready),
    .i_wr_ch    (wr_ch),
    .i_wr_pos   (wr_pos),
    .i_wr_rate  (wr_rate),
    .o_pos_out  (pos_out),
    .o_busy     (busy),
    .o_tick     (tick)
  );

  typedef struct {
    logic [31:0] pos;
    logic [3:0]  busy;
    bit          pos_v;
    bit          busy_v;
    bit          ready;
    bit          tick;
  } exp_t;

  exp_t sb_q[$];

  int m_cur  [NCH];
  int m_tgt  [NCH];
  int m_rate [NCH];
  int m_cyc;
  bit m_ready;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got=%0d expected=%0d", name, $time, got, exp);
    end
  endtask

  // Reference model: cycles counted from reset release; a tick every SD clocks,
  // the NCH cycles after it are the scan window, and the whole scan's effect is
  // applied at once when the window closes.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) begin
        m_cur[k]  = RP;
        m_tgt[k]  = RP;
        m_rate[k] = 0;
      end
      m_cyc   = 0;
      m_ready = 1'b1;
      sb_q.delete();
    end else begin
      exp_t e;
      int   ph;
      bit   scanning;
      int   ch;
      for (int k = 0; k < NCH; k++) e.busy[k] = (m_cur[k] != m_tgt[k]);
      if (m_ready && wr_valid) begin
        ch = int'(wr_ch);
        m_tgt[ch]  = int'(wr_pos);
        m_rate[ch] = int'(wr_rate);
        if (wr_rate == 4'd0) m_cur[ch] = int'(wr_pos);
      end
      m_cyc++;
      ph = m_cyc % SD;
      if (m_cyc > SD && ph == NCH + 1) begin
        for (int k = 0; k < NCH; k++) begin
          if (m_cur[k] < m_tgt[k])
            m_cur[k] = (m_cur[k] + m_rate[k] > m_tgt[k]) ? m_tgt[k] : m_cur[k] + m_rate[k];
          else if (m_cur[k] > m_tgt[k])
            m_cur[k] = (m_cur[k] - m_rate[k] < m_tgt[k]) ? m_tgt[k] : m_cur[k] - m_rate[k];
        end
      end
      scanning = (m_cyc > SD) && (ph >= 1) && (ph <= NCH);
      m_ready  = !scanning;
      e.tick   = (ph == 0);
      e.ready  = m_ready;
      e.pos_v  = !scanning;
      e.busy_v = !((m_cyc > SD) && (ph >= 1) && (ph <= NCH + 1));
      for (int k = 0; k < NCH; k++) e.pos[8*k +: 8] = 8'(m_cur[k]);
      sb_q.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (!rst && sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("tick", 32'(tick), 32'(e.tick));
      chk("wr_ready", 32'(wr_ready), 32'(e.ready));
      if (e.pos_v)  chk("pos_out", pos_out, e.pos);
      if (e.busy_v) chk("busy", 32'(busy), 32'(e.busy));
    end
  end

  function automatic int lane(input int ch);
    return int'(pos_out[8*ch +: 8]);
  endfunction

  task automatic wait_tick();
    bit seen = 1'b0;
    for (int i = 0; i < 4*SD && !seen; i++) begin
      @(negedge clk);
      if (tick) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_err++;
      $display("FAIL wait_tick: got=no tick expected=tick within %0d cycles", 4*SD);
    end
  endtask

  task automatic wait_scan_done();
    wait_tick();
    repeat (NCH + 1) @(negedge clk);
  endtask

  task automatic measure_first_tick();
    int  n = 0;
    bit  seen = 1'b0;
    for (int i = 0; i < 4*SD && !seen; i++) begin
      @(negedge clk);
      n++;
      if (tick) seen = 1'b1;
    end
    chk("first_tick_cycles", 32'(n), 32'(SD));
  endtask

  // Called at a negedge; holds wr_valid until the DUT takes it.
  task automatic do_write(input int ch, input int pos, input int rate, output int stalls);
    bit done = 1'b0;
    stalls   = 0;
    wr_valid = 1'b1;
    wr_ch    = 2'(ch);
    wr_pos   = 8'(pos);
    wr_rate  = 4'(rate);
    for (int i = 0; i < 64 && !done; i++) begin
      if (wr_ready) done = 1'b1;
      else stalls++;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    if (!done) begin
      n_checks++;
      n_err++;
      $display("FAIL write_timeout: got=no accept expected=accept on ch%0d", ch);
    end
  endtask

  task automatic random_writes(input int count);
    int s;
    for (int i = 0; i < count; i++) begin
      repeat ($urandom_range(0, 20)) @(negedge clk);
      do_write(int'($urandom_range(0, NCH-1)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 15)), s);
    end
  endtask

  initial begin
    int s;
    int prev;
    int exp_up [4] = '{133, 138, 140, 140};
    int exp_rc [6] = '{30, 40, 50, 60, 60, 60};

    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    chk("rst_pos_out", pos_out, {4{8'd128}});
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_tick", 32'(tick), 32'd0);
    measure_first_tick();

    do_write(1, 200, 0, s);
    chk("jump_pos", 32'(lane(1)), 32'd200);
    chk("jump_busy", 32'(busy[1]), 32'd0);

    do_write(0, 140, 5, s);
    for (int i = 0; i < 4; i++) begin
      wait_scan_done();
      chk("ramp_up_pos", 32'(lane(0)), 32'(exp_up[i]));
      if (i == 2) begin
        @(negedge clk);
        chk("ramp_up_busy_clear", 32'(busy[0]), 32'd0);
      end
    end

    do_write(3, 10, 0, s);
    do_write(3, 0, 15, s);
    wait_scan_done();
    chk("ramp_down_zero", 32'(lane(3)), 32'd0);
    @(negedge clk);
    chk("ramp_down_busy", 32'(busy[3]), 32'd0);

    wait_tick();
    do_write(2, 140, 15, s);
    chk("tick_write_stalls", 32'(s), 32'd0);
    repeat (NCH) @(negedge clk);
    chk("tick_write_scan", 32'(lane(2)), 32'd140);

    wait_tick();
    @(negedge clk);
    do_write(0, 90, 3, s);
    chk("stall_cycles", 32'(s), 32'(NCH));

    do_write(2, 20, 0, s);
    do_write(2, 50, 10, s);
    do_write(2, 60, 10, s);
    prev = lane(2);
    for (int i = 0; i < 6; i++) begin
      wait_scan_done();
      chk("race_pos", 32'(lane(2)), 32'(exp_rc[i]));
      chk("race_le_60", 32'(lane(2) <= 60), 32'd1);
      chk("race_monotonic", 32'(lane(2) >= prev), 32'd1);
      prev = lane(2);
    end

    random_writes(40);

    wait_tick();
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midscan_rst_pos", pos_out, {4{8'd128}});
    chk("midscan_rst_busy", 32'(busy), 32'd0);
    chk("midscan_rst_ready", 32'(wr_ready), 32'd1);
    chk("midscan_rst_tick", 32'(tick), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    measure_first_tick();

    random_writes(25);
    repeat (3*SD) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/servo_ramp_ctrl.md
Name: servo_ramp_ctrl

Overview:
- Rate-limited position scheduler for a bank of NCH servo channels.
- Holds per-channel target position and slew rate, written over a valid/ready port.
- Once per ramp period, steps each channel's current position toward its target, one channel per clock, round-robin.
- pos_out lanes feed the 8-bit pos inputs of the per-channel servo PWM generators; only this block drives them.

Parameters:
- NCH, 4, number of servo channels (2..16).
- STEP_DIV, 240000, clk cycles per ramp tick (20 ms at 12 MHz); must be >= NCH+2.
- RST_POS, 128, reset value of every target and current position (servo centre).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when wr_valid & wr_ready
- wr_ch  in  $clog2(NCH)  channel index
- wr_pos  in  8  target position 0..255
- wr_rate  in  4  step per tick; 0 = jump immediately
- pos_out  out  NCH*8  current positions; channel k on bits [8k+7:8k]
- busy  out  NCH  bit k high while current[k] != target[k]
- tick  out  1  one-cycle pulse at each ramp tick

Behaviour:
- Reset (async, any time, including mid-scan):
  - all current and target = RST_POS, all rates = 0
  - divider = 0, state = IDLE
  - tick = 0, busy = 0, wr_ready = 1
- Divider:
  - Counts 0..STEP_DIV-1 and wraps.
  - tick registered high for exactly one cycle when the divider equals STEP_DIV-1; period is exactly STEP_DIV cycles.
  - Runs free in all states.
- FSM states: IDLE, SCAN.
  - IDLE -> SCAN on the cycle after tick; scan index idx = 0.
  - SCAN processes channel idx each cycle. If idx == NCH-1, return to IDLE; otherwise idx+1.
  - A scan takes exactly NCH cycles; the STEP_DIV constraint guarantees no tick arrives during SCAN.
- Step rule for channel idx, 9-bit arithmetic, no wrap:
  - cur < tgt: cur <= min(cur + rate, tgt)
  - cur > tgt: cur <= max(cur - rate, tgt)
  - equal, or rate = 0: no change
- Writes:
  - wr_ready = (state == IDLE). Writes are stalled only during the NCH scan cycles.
  - On accept: target[wr_ch] <= wr_pos, rate[wr_ch] <= wr_rate.
  - If wr_rate == 0, current[wr_ch] <= wr_pos on the same edge; visible on pos_out the next cycle.
  - A write in the same cycle as tick is accepted, and the following scan uses the new target.
  - Back-to-back writes to the same channel: last one wins.
  - wr_ch >= NCH (non-power-of-two NCH): write is accepted and discarded.
- Outputs are registered. busy[k] is updated from registered cur/tgt, so it lags one cycle behind any change to them.
- Overshoot is impossible: the clamp to target applies even with rate 15 and a 1-LSB distance.
- Endpoints: 0 and 255 are reached exactly; no 8-bit wrap (for example, 250 + 15 clamps to a target of 255).

Decomposition:
- Shared package (servo_pkg) holds:
  - position width (8) and rate width (4)
  - default RST_POS
  - STEP_DIV value for the 12 MHz board clock
- One natural sub-module: servo_tick_div (free-running modulo-STEP_DIV counter with a registered tick). It is reusable by the PWM side.
- The step/clamp logic stays inline; it is a single shared datapath indexed by idx.

Test Plan (NCH=4, STEP_DIV=16 for simulation):
- Reset mid-scan:
  - Stimulus: assert rst during SCAN at idx=2.
  - Response: immediately, all pos_out lanes = 128, busy = 0, wr_ready = 1; the first tick comes 16 cycles after release.
- Jump write:
  - Stimulus: write ch1, pos = 200, rate = 0, in IDLE.
  - Response: pos_out[15:8] = 200 the next cycle; busy[1] never rises.
- Ramp up:
  - Stimulus: write ch0, pos = 140, rate = 5, from 128.
  - Response: successive ticks give 133, 138, 140, then hold; busy[0] drops after the third step.
- Ramp down to 0:
  - Stimulus: write ch3, pos = 0, rate = 15, from 10.
  - Response: first scan gives 0 (no wrap to 251); busy[3] clears.
- Stall and simultaneity:
  - Stimulus: hold wr_valid during SCAN; also write in the tick cycle.
  - Response:
    - wr_ready is low for exactly 4 cycles and the write completes on the first IDLE cycle.
    - The tick-cycle write's target is used by the immediately following scan.
- Same-channel race:
  - Stimulus: two consecutive writes to ch2 (pos 50, then pos 60, both rate 10).
  - Response: the ramp converges to 60; intermediate values never exceed 60 or fall below 50 once decreasing.
